// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_sequencer_pkg : shared FSM encoding and PC step constants           |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
package pc_sequencer_pkg;

    typedef enum logic [0:0] {
        ST_SEQ  = 1'b0,
        ST_SLOT = 1'b1
    } seq_state_e;

    localparam int unsigned PC_INC = 4;

    // With a delay slot the link skips both the branch and its slot.
    function automatic int unsigned link_offset(input int delay_slot);
        return (delay_slot != 0) ? 2 * PC_INC : PC_INC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_sequencer_if : control inputs and fetch-status outputs of the PC   |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
interface pc_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             redirect;
    logic [WIDTH-1:0] target;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] pc;
    logic             in_slot;
    logic             ras_empty;
    logic             ras_full;
    logic             fault;

    modport master (
        output stall, redirect, target, call, ret,
        input  pc, in_slot, ras_empty, ras_full, fault
    );

    modport slave (
        input  stall, redirect, target, call, ret,
        output pc, in_slot, ras_empty, ras_full, fault
    );
endinterface
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_ras : circular return-address stack, oldest entry lost on overflow |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module pc_ras #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  wire logic             clk_i,
    input  wire logic             rst_ni,
    input  wire logic             push_i,
    input  wire logic             pop_i,
    input  wire logic [WIDTH-1:0] push_data_i,
    output logic      [WIDTH-1:0] top_o,
    output logic                  empty_o,
    output logic                  full_o
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] sp_q, sp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W-1:0] wr_idx;
    logic             pop_ok;

    assign top_idx = sp_q - PTR_W'(1);
    assign pop_ok  = pop_i && (cnt_q != '0);
    // A simultaneous pop and push rewrites the top slot in place.
    assign wr_idx  = pop_ok ? top_idx : sp_q;

    always_comb begin
        sp_d  = sp_q;
        cnt_d = cnt_q;
        case ({push_i, pop_ok})
            2'b10: begin
                sp_d = sp_q + PTR_W'(1);
                if (cnt_q != C_DEPTH) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            2'b01: begin
                sp_d  = top_idx;
                cnt_d = cnt_q - CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sp_q  <= '0;
            cnt_q <= '0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_idx] <= push_data_i;
        end
    end

    assign top_o   = mem_q[top_idx];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == C_DEPTH);

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_sequencer : fetch PC with optional MIPS delay slot and RAS         |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               DELAY_SLOT   = 1,
    parameter int               RAS_DEPTH    = 4
) (
    input  wire logic     clk_i,
    input  wire logic     rst_ni,
    pc_sequencer_if.slave bus
);
    localparam logic [WIDTH-1:0] C_RV   = {RESET_VECTOR[WIDTH-1:2], 2'b00};
    localparam logic [WIDTH-1:0] C_INC  = WIDTH'(PC_INC);
    localparam logic [WIDTH-1:0] C_LINK = WIDTH'(link_offset(DELAY_SLOT));
    localparam bit               C_HAS_SLOT = (DELAY_SLOT != 0);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic             fault_q, fault_d;

    logic             ras_push;
    logic             ras_pop;
    logic [WIDTH-1:0] ras_push_data;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty;
    logic             ras_full;

    logic             transfer;
    logic [WIDTH-1:0] dest;
    logic [WIDTH-1:0] dest_aligned;

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (ras_push_data),
        .top_o       (ras_top),
        .empty_o     (ras_empty),
        .full_o      (ras_full)
    );

    assign transfer      = bus.redirect | bus.ret;
    // An empty-stack return falls back to Target, like a plain jump.
    assign dest          = (bus.ret && !ras_empty) ? ras_top : bus.target;
    assign dest_aligned  = {dest[WIDTH-1:2], 2'b00};
    assign ras_push_data = pc_q + C_LINK;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        tgt_d    = tgt_q;
        fault_d  = fault_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        if (!bus.stall) begin
            case (state_q)
                ST_SEQ: begin
                    pc_d = pc_q + C_INC;
                    if (transfer) begin
                        ras_pop  = bus.ret & ~ras_empty;
                        ras_push = bus.call;
                        fault_d  = fault_q | (dest[1:0] != 2'b00);
                        if (C_HAS_SLOT) begin
                            tgt_d   = dest_aligned;
                            state_d = ST_SLOT;
                        end else begin
                            pc_d = dest_aligned;
                        end
                    end
                end
                ST_SLOT: begin
                    pc_d    = tgt_q;
                    state_d = ST_SEQ;
                end
                default: state_d = ST_SEQ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_SEQ;
            pc_q    <= C_RV;
            tgt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            fault_q <= fault_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.in_slot   = (state_q == ST_SLOT);
    assign bus.ras_empty = ras_empty;
    assign bus.ras_full  = ras_full;
    assign bus.fault     = fault_q;

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, sets PC and target width in bits (min 8).
REQ-002 Parameter RESET_VECTOR, default 0, is the PC value loaded on reset; its low 2 bits SHALL be 0.
REQ-003 Parameter DELAY_SLOT, default 1; 1 means MIPS branch-delay-slot sequencing, 0 means immediate redirect.
REQ-004 Parameter RAS_DEPTH, default 4, sets the return-address-stack depth (power of 2, at least 2).
REQ-005 Clock  in  1  sole clock; all state changes on its rising edge.
REQ-006 Reset_L  in  1  asynchronous, active-low reset.
REQ-007 Stall  in  1  holds all state when 1.
REQ-008 Redirect  in  1  request a control transfer to Target.
REQ-009 Target  in  WIDTH  branch/jump destination.
REQ-010 Call  in  1  with Redirect, push the return address (jal).
REQ-011 Return  in  1  control transfer to the RAS top and pop (jr $ra); needs no Redirect.
REQ-012 PC  out  WIDTH  current fetch address.
REQ-013 InSlot  out  1  1 while the current PC is a delay-slot fetch with a transfer pending.
REQ-014 RasEmpty / RasFull  out  1 each  RAS occupancy flags.
REQ-015 Fault  out  1  sticky misaligned-target flag.

Function
REQ-016 The FSM SHALL have two states: SEQ and SLOT. SLOT is unreachable when DELAY_SLOT=0.
REQ-017 When Stall=1, PC, state, RAS, latched target and Fault SHALL all hold, and Redirect, Call and Return SHALL be ignored.
REQ-018 In SEQ with no transfer, PC SHALL become PC+4 modulo 2^WIDTH; wrap from 2^WIDTH-4 to 0 SHALL occur with no flag.
REQ-019 A transfer is Return=1 or Redirect=1; its destination SHALL be the RAS top on Return with a non-empty RAS, else Target.
REQ-020 With DELAY_SLOT=1, a transfer in SEQ SHALL set PC to PC+4, latch the destination and enter SLOT with InSlot=1.
REQ-021 In SLOT on the next unstalled edge, PC SHALL take the latched destination and the FSM SHALL return to SEQ.
REQ-022 With DELAY_SLOT=1, Redirect, Call and Return SHALL be ignored while in SLOT; no RAS change SHALL occur.
REQ-023 With DELAY_SLOT=0, a transfer SHALL load the destination into PC on the same edge.
REQ-024 Call with Redirect SHALL push the address of the requesting instruction + 8 (DELAY_SLOT=1) or + 4 (DELAY_SLOT=0), modulo 2^WIDTH.
REQ-025 Call without Redirect and without Return SHALL have no effect.
REQ-026 Push when full SHALL overwrite the oldest entry; occupancy stays RAS_DEPTH and RasFull stays 1.
REQ-027 Return with an empty RAS SHALL use Target as the destination, leave the RAS unchanged and not set Fault.
REQ-028 Call and Return together SHALL pop first, then push; the net effect is that the top entry is replaced and occupancy is unchanged.
REQ-029 A destination with nonzero bits [1:0] SHALL set Fault, and PC SHALL load the destination with bits [1:0] forced to 0.
REQ-030 Fault SHALL clear only on reset.
REQ-031 PC[1:0] SHALL always be 0.

Reset
REQ-032 While Reset_L=0: PC=RESET_VECTOR, state SEQ, InSlot=0, RAS occupancy 0, RasEmpty=1, RasFull=0, Fault=0, latched target 0.
REQ-033 Reset asserted mid-SLOT SHALL discard the pending transfer; the first edge after release SHALL give PC=RESET_VECTOR+4.
REQ-034 RAS entry storage need not be cleared; only the pointers and count reset.

Structure
REQ-035 The shared package SHALL hold the FSM state encoding (SEQ, SLOT) and the increment constant 4.
REQ-036 The RAS SHALL be a sub-module, pc_ras, parameterised by WIDTH and RAS_DEPTH, with push/pop/top/empty/full ports.

Verification
REQ-037 Reset, then 3 unstalled edges with RESET_VECTOR=0x100 -> PC sequence 0x100, 0x104, 0x108, 0x10C.
REQ-038 DELAY_SLOT=1: at PC=0x200 pulse Redirect with Target=0x400 -> next PC 0x204 with InSlot=1, then 0x400 with InSlot=0.
REQ-039 DELAY_SLOT=1: Call+Redirect at 0x300 to 0x800, run, then Return at 0x810 -> PC 0x814, then 0x308, and RasEmpty=1.
REQ-040 RAS_DEPTH=4: 5 calls pushing A..E, then 5 returns -> pops E, D, C, B, then the fifth return goes to Target, with RasFull=1 after the 4th push.
REQ-041 Stall held 3 cycles during SLOT -> PC and InSlot frozen, and the transfer completes on the first unstalled edge.
REQ-042 Redirect to 0x402 -> PC 0x400 and Fault=1, which persists until Reset_L=0; Reset_L asserted mid-SLOT -> PC=RESET_VECTOR immediately.
